// File: rtl/sram_like_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_pkg
// Description : Shared definitions for the SRAM-like bus multiplexer:
//               transfer size encodings and index/count width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_pkg;

    // Transfer size encodings carried on s_size / m_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Bits needed to index n items (at least one bit)
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to n inclusive (n a power of two)
    function automatic int cnt_width(input int n);
        return id_width(n) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_id_fifo
// Description : In-order FIFO of channel IDs for outstanding transactions.
//               Register-array storage, pointers wrap naturally at DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_id_fifo
    import sram_like_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_PW = id_width(DEPTH);
    localparam int c_CW = cnt_width(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    // A push into a full FIFO or a pop from an empty one is ignored
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_count == c_CW'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rptr];
    assign count = r_count;

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_mux.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_mux
// Description : N-to-1 SRAM-like bus multiplexer. Round-robin arbitration
//               with grant lock until acceptance; an in-order ID FIFO routes
//               each downstream response back to its issuing channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_mux
    import sram_like_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        s_req,
    input  logic [NCH-1:0]        s_wr,
    input  logic [2*NCH-1:0]      s_size,
    input  logic [AW*NCH-1:0]     s_addr,
    input  logic [(DW/8)*NCH-1:0] s_wstrb,
    input  logic [DW*NCH-1:0]     s_wdata,
    output logic [NCH-1:0]        s_addr_ok,
    output logic [NCH-1:0]        s_data_ok,
    output logic [DW-1:0]         s_rdata,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [AW-1:0]         m_addr,
    output logic [DW/8-1:0]       m_wstrb,
    output logic [DW-1:0]         m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DW-1:0]         m_rdata,
    output logic                  err_unexp_rsp
);

    localparam int c_IW = id_width(NCH);
    localparam int c_CW = cnt_width(MAX_OUT);
    localparam int c_SW = DW / 8;

    logic [c_IW-1:0] r_ptr;
    logic            r_lock_v;
    logic [c_IW-1:0] r_lock_id;

    logic [c_IW-1:0] w_rr_gnt;
    logic [c_IW-1:0] w_gnt;
    logic [c_IW-1:0] w_gnt_next;
    logic            w_lock_hold;
    logic            w_accept;
    logic            w_rsp;
    logic            w_full;
    logic            w_empty;
    logic [c_IW-1:0] w_head;
    logic [c_CW-1:0] w_count;

    // Cyclic search for the first requester at or after the priority pointer
    always_comb begin
        int  idx;
        logic found;
        w_rr_gnt = r_ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && s_req[idx]) begin
                found    = 1'b1;
                w_rr_gnt = c_IW'(idx);
            end
        end
    end

    // A locked channel keeps the grant only while it still requests
    assign w_lock_hold = r_lock_v & s_req[r_lock_id];
    assign w_gnt       = w_lock_hold ? r_lock_id : w_rr_gnt;
    assign w_gnt_next  = (int'(w_gnt) == NCH - 1) ? '0 : w_gnt + 1'b1;

    // Request path: granted channel's fields go straight downstream
    assign m_req   = s_req[w_gnt] & ~w_full & ~reset;
    assign m_wr    = s_wr[w_gnt];
    assign m_size  = s_size[int'(w_gnt)*2 +: 2];
    assign m_addr  = s_addr[int'(w_gnt)*AW +: AW];
    assign m_wstrb = s_wstrb[int'(w_gnt)*c_SW +: c_SW];
    assign m_wdata = s_wdata[int'(w_gnt)*DW +: DW];

    assign w_accept = m_req & m_addr_ok;
    assign w_rsp    = m_data_ok & ~w_empty & ~reset;

    assign s_rdata       = m_rdata;
    assign err_unexp_rsp = m_data_ok & w_empty & ~reset;

    // One-hot acknowledge to the granted channel on acceptance
    always_comb begin
        s_addr_ok = '0;
        if (w_accept) begin
            s_addr_ok[w_gnt] = 1'b1;
        end
    end

    // One-hot response strobe to the channel at the FIFO head
    always_comb begin
        s_data_ok = '0;
        if (w_rsp) begin
            s_data_ok[w_head] = 1'b1;
        end
    end

    // Priority pointer advances past each accepted channel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_gnt_next;
        end
    end

    // Hold a presented-but-unaccepted request stable; drop on accept or withdraw
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_v  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_accept) begin
            r_lock_v <= 1'b0;
        end else if (m_req) begin
            r_lock_v  <= 1'b1;
            r_lock_id <= w_gnt;
        end else if (r_lock_v && !s_req[r_lock_id]) begin
            r_lock_v <= 1'b0;
        end
    end

    sram_like_id_fifo #(
        .W     (c_IW),
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_accept),
        .pop   (w_rsp),
        .din   (w_gnt),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Occupancy is fully summarised by full/empty at this level
    logic w_unused;
    assign w_unused = ^w_count;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_mux
// Description : Directed self-checking bench for sram_like_mux (NCH=2,
//               MAX_OUT=4) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_mux;
    import sram_like_pkg::*;

    localparam int NCH     = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;

    logic                  clk;
    logic                  reset;
    logic [NCH-1:0]        s_req;
    logic [NCH-1:0]        s_wr;
    logic [2*NCH-1:0]      s_size;
    logic [AW*NCH-1:0]     s_addr;
    logic [(DW/8)*NCH-1:0] s_wstrb;
    logic [DW*NCH-1:0]     s_wdata;
    logic [NCH-1:0]        s_addr_ok;
    logic [NCH-1:0]        s_data_ok;
    logic [DW-1:0]         s_rdata;
    logic                  m_req;
    logic                  m_wr;
    logic [1:0]            m_size;
    logic [AW-1:0]         m_addr;
    logic [DW/8-1:0]       m_wstrb;
    logic [DW-1:0]         m_wdata;
    logic                  m_addr_ok;
    logic                  m_data_ok;
    logic [DW-1:0]         m_rdata;
    logic                  err_unexp_rsp;

    int vectors    = 0;
    int miscompares = 0;

    sram_like_mux #(
        .NCH     (NCH),
        .AW      (AW),
        .DW      (DW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_req         (s_req),
        .s_wr          (s_wr),
        .s_size        (s_size),
        .s_addr        (s_addr),
        .s_wstrb       (s_wstrb),
        .s_wdata       (s_wdata),
        .s_addr_ok     (s_addr_ok),
        .s_data_ok     (s_data_ok),
        .s_rdata       (s_rdata),
        .m_req         (m_req),
        .m_wr          (m_wr),
        .m_size        (m_size),
        .m_addr        (m_addr),
        .m_wstrb       (m_wstrb),
        .m_wdata       (m_wdata),
        .m_addr_ok     (m_addr_ok),
        .m_data_ok     (m_data_ok),
        .m_rdata       (m_rdata),
        .err_unexp_rsp (err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the sequence is linear, so this only fires on a simulator stall
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int ch, input logic req, input logic wr, input logic [1:0] size,
                          input logic [AW-1:0] addr, input logic [DW/8-1:0] wstrb,
                          input logic [DW-1:0] wdata);
        s_req[ch]                 = req;
        s_wr[ch]                  = wr;
        s_size[ch*2 +: 2]         = size;
        s_addr[ch*AW +: AW]       = addr;
        s_wstrb[ch*(DW/8) +: DW/8] = wstrb;
        s_wdata[ch*DW +: DW]      = wdata;
    endtask

    initial begin
        reset     = 1'b1;
        s_req     = '0;
        s_wr      = '0;
        s_size    = '0;
        s_addr    = '0;
        s_wstrb   = '0;
        s_wdata   = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = '0;

        // ---- Reset: all outputs low even with everything asserted ----
        set_ch(0, 1'b1, 1'b0, SZ_WORD, 32'h0000_0100, 4'h0, 32'h0);
        set_ch(1, 1'b1, 1'b0, SZ_WORD, 32'h0000_0200, 4'h0, 32'h0);
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        #1;
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_addr_ok", 64'(s_addr_ok), 64'd0);
        chk("rst_data_ok", 64'(s_data_ok), 64'd0);
        chk("rst_err", 64'(err_unexp_rsp), 64'd0);
        tick();
        tick();
        s_req = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        reset = 1'b0;

        // ---- Single read from ch0 ----
        set_ch(0, 1'b1, 1'b0, SZ_WORD, 32'h1fc0_0000, 4'h0, 32'h0);
        m_addr_ok = 1'b1;
        #1;
        chk("rd_m_req", 64'(m_req), 64'd1);
        chk("rd_m_addr", 64'(m_addr), 64'h1fc0_0000);
        chk("rd_m_wr", 64'(m_wr), 64'd0);
        chk("rd_addr_ok", 64'(s_addr_ok), 64'b01);
        chk("rd_data_ok_c0", 64'(s_data_ok), 64'b00);
        tick();
        s_req[0] = 1'b0;
        m_addr_ok = 1'b0;
        #1;
        chk("rd_data_ok_c1", 64'(s_data_ok), 64'b00);
        tick();
        m_data_ok = 1'b1;
        m_rdata = 32'h1234_5678;
        #1;
        chk("rd_data_ok_c2", 64'(s_data_ok), 64'b01);
        chk("rd_rdata", 64'(s_rdata), 64'h1234_5678);
        chk("rd_err", 64'(err_unexp_rsp), 64'd0);
        tick();
        m_data_ok = 1'b0;

        // Reset again so the priority pointer restarts at 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---- Round-robin: both request, grants 0,1,0,1 then full ----
        set_ch(0, 1'b1, 1'b0, SZ_WORD, 32'h0000_1000, 4'h0, 32'h0);
        set_ch(1, 1'b1, 1'b0, SZ_WORD, 32'h0000_2000, 4'h0, 32'h0);
        m_addr_ok = 1'b1;
        #1;
        chk("rr0_addr", 64'(m_addr), 64'h1000);
        chk("rr0_ok", 64'(s_addr_ok), 64'b01);
        tick();
        #1;
        chk("rr1_addr", 64'(m_addr), 64'h2000);
        chk("rr1_ok", 64'(s_addr_ok), 64'b10);
        tick();
        #1;
        chk("rr2_addr", 64'(m_addr), 64'h1000);
        chk("rr2_ok", 64'(s_addr_ok), 64'b01);
        tick();
        #1;
        chk("rr3_addr", 64'(m_addr), 64'h2000);
        chk("rr3_ok", 64'(s_addr_ok), 64'b10);
        tick();

        // ---- Full: no request, a pop this cycle does not unblock ----
        #1;
        chk("full_m_req", 64'(m_req), 64'd0);
        chk("full_ok", 64'(s_addr_ok), 64'b00);
        m_data_ok = 1'b1;
        #1;
        chk("full_pop_data_ok", 64'(s_data_ok), 64'b01);
        chk("full_pop_m_req", 64'(m_req), 64'd0);
        chk("full_pop_ok", 64'(s_addr_ok), 64'b00);
        tick();
        m_data_ok = 1'b0;
        #1;
        // Pointer is back at 0 after ch1's last accept
        chk("unblk_m_req", 64'(m_req), 64'd1);
        chk("unblk_ok", 64'(s_addr_ok), 64'b01);
        tick();

        // Drain: FIFO holds 1,0,1,0
        s_req = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("drain0", 64'(s_data_ok), 64'b10);
        tick();
        #1;
        chk("drain1", 64'(s_data_ok), 64'b01);
        tick();
        #1;
        chk("drain2", 64'(s_data_ok), 64'b10);
        tick();
        #1;
        chk("drain3", 64'(s_data_ok), 64'b01);
        tick();
        m_data_ok = 1'b0;

        // One ch1 transaction to bring the pointer back to 0
        set_ch(1, 1'b1, 1'b1, SZ_WORD, 32'h0000_2004, 4'hf, 32'h5555_aaaa);
        m_addr_ok = 1'b1;
        #1;
        chk("pre_lock_ok", 64'(s_addr_ok), 64'b10);
        tick();
        s_req = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("pre_lock_rsp", 64'(s_data_ok), 64'b10);
        tick();
        m_data_ok = 1'b0;

        // ---- Lock: ch1 presented, ch0 arrives, ch1 keeps the bus ----
        set_ch(1, 1'b1, 1'b0, SZ_WORD, 32'h0000_3000, 4'h0, 32'h0);
        #1;
        chk("lk0_addr", 64'(m_addr), 64'h3000);
        chk("lk0_ok", 64'(s_addr_ok), 64'b00);
        tick();
        set_ch(0, 1'b1, 1'b0, SZ_WORD, 32'h0000_1100, 4'h0, 32'h0);
        #1;
        chk("lk1_addr", 64'(m_addr), 64'h3000);
        chk("lk1_ok", 64'(s_addr_ok), 64'b00);
        tick();
        #1;
        chk("lk2_addr", 64'(m_addr), 64'h3000);
        tick();
        m_addr_ok = 1'b1;
        #1;
        chk("lk3_addr", 64'(m_addr), 64'h3000);
        chk("lk3_ok", 64'(s_addr_ok), 64'b10);
        tick();
        s_req[1] = 1'b0;
        #1;
        chk("lk4_addr", 64'(m_addr), 64'h1100);
        chk("lk4_ok", 64'(s_addr_ok), 64'b01);
        tick();
        s_req = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("lk_rsp0", 64'(s_data_ok), 64'b10);
        tick();
        #1;
        chk("lk_rsp1", 64'(s_data_ok), 64'b01);
        tick();
        m_data_ok = 1'b0;

        // ---- Lock release: pointer at 1, ch1 locks, then withdraws ----
        s_req = 2'b11;
        #1;
        chk("rel0_addr", 64'(m_addr), 64'h3000);
        chk("rel0_m_req", 64'(m_req), 64'd1);
        tick();
        s_req[1] = 1'b0;
        m_addr_ok = 1'b1;
        #1;
        chk("rel1_addr", 64'(m_addr), 64'h1100);
        chk("rel1_ok", 64'(s_addr_ok), 64'b01);
        tick();
        s_req = '0;

        // ---- Reset mid-flight with two outstanding ----
        set_ch(1, 1'b1, 1'b0, SZ_WORD, 32'h0000_3004, 4'h0, 32'h0);
        #1;
        chk("mf_ok", 64'(s_addr_ok), 64'b10);
        tick();
        s_req = '0;
        m_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        chk("mf_rst_m_req", 64'(m_req), 64'd0);
        tick();
        reset = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("mf_err", 64'(err_unexp_rsp), 64'd1);
        chk("mf_data_ok", 64'(s_data_ok), 64'b00);
        tick();
        m_data_ok = 1'b0;
        #1;
        chk("mf_err_clr", 64'(err_unexp_rsp), 64'd0);

        // Half-word write from ch1 after recovery
        set_ch(1, 1'b1, 1'b1, SZ_HALF, 32'h0000_4000, 4'h3, 32'haabb_ccdd);
        m_addr_ok = 1'b1;
        #1;
        chk("wr_ok", 64'(s_addr_ok), 64'b10);
        chk("wr_m_wr", 64'(m_wr), 64'd1);
        chk("wr_size", 64'(m_size), 64'(SZ_HALF));
        chk("wr_addr", 64'(m_addr), 64'h4000);
        chk("wr_wstrb", 64'(m_wstrb), 64'h3);
        chk("wr_wdata", 64'(m_wdata), 64'haabb_ccdd);
        tick();
        s_req = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        #1;
        chk("wr_rsp", 64'(s_data_ok), 64'b10);
        chk("wr_err", 64'(err_unexp_rsp), 64'd0);
        tick();
        m_data_ok = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_like_mux.md
# sram_like_mux

Parametrised N-to-1 multiplexer for the SRAM-like bus (req/addr_ok/data_ok). It sits between the CPU's instruction and data request ports and a single downstream bridge or memory port. It arbitrates requests round-robin and holds a granted request stable until accepted. An in-order ID FIFO records which channel owns each outstanding transaction, so it can route each response back to the right channel.

## Interface
Parameters:
- `NCH`, 2, number of upstream channels (≥2).
- `AW`, 32, address width.
- `DW`, 32, data width; strobe width is DW/8.
- `MAX_OUT`, 4, maximum outstanding transactions (power of two, ≥2).

Ports (per-channel buses are flattened, channel i at slice i):
- `clk` in 1, sole clock; all state updates on posedge.
- `reset` in 1, synchronous, active-high.
- `s_req` in NCH, per-channel request.
- `s_wr` in NCH, 1 = write.
- `s_size` in 2*NCH, byte count encoding: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes.
- `s_addr` in AW*NCH, request address.
- `s_wstrb` in (DW/8)*NCH, write byte strobes.
- `s_wdata` in DW*NCH, write data.
- `s_addr_ok` out NCH, request accepted.
- `s_data_ok` out NCH, response delivered.
- `s_rdata` out DW, `m_rdata` broadcast to all channels; qualified by `s_data_ok`.
- `m_req`, `m_wr`, `m_size`, `m_addr`, `m_wstrb`, `m_wdata` out (1, 1, 2, AW, DW/8, DW): the granted channel's request.
- `m_addr_ok` in 1, downstream accepts.
- `m_data_ok` in 1, downstream response.
- `m_rdata` in DW, downstream read data.
- `err_unexp_rsp` out 1, one-cycle pulse: `m_data_ok` arrived with no transaction outstanding.

## Operation
- **Request path is combinational.** `m_*` carries the fields of channel `gnt`. `m_req = s_req[gnt] & ~full & ~reset`.
- **Acceptance** = `m_req & m_addr_ok`. On acceptance:
  - `s_addr_ok[gnt]` = 1 (same cycle, combinational).
  - push `gnt` into the ID FIFO.
  - the priority pointer moves to `gnt+1` mod NCH.
- **Grant selection:**
  - If `lock_v` is set and `s_req[lock_id]` is high, `gnt = lock_id`.
  - Otherwise `gnt` is the first requesting channel at or after the pointer, searching cyclically.
  - If no channel requests, `gnt` = pointer and `m_req` = 0.
- **Lock:**
  - Set `lock_v`, and `lock_id = gnt`, when `m_req & ~m_addr_ok`.
  - Clear `lock_v` on acceptance, or when `s_req[lock_id]` falls. A channel that withdraws its request gives up the lock, and arbitration resumes that same cycle.
- **Full:**
  - `full` = count == MAX_OUT.
  - While full, `m_req` = 0 and every `s_addr_ok` = 0.
  - A pop in the same cycle does not unblock; acceptance resumes the following cycle.
- **Response path:**
  - On `m_data_ok` with the FIFO non-empty: `s_data_ok[head]` = 1 combinationally, then pop.
  - On `m_data_ok` with the FIFO empty: the response is dropped, all `s_data_ok` stay 0, and `err_unexp_rsp` = 1 that cycle.
- **Simultaneous push and pop (not full):** count is unchanged, and head/tail both advance with wrap at MAX_OUT.
- **Count** is $clog2(MAX_OUT)+1 bits wide. Pointers are $clog2(MAX_OUT) bits and wrap naturally.

## Timing
- Reset state: FIFO empty (count 0, pointers 0), priority pointer 0, `lock_v` 0.
- While `reset` is high, all outputs are 0: `m_req`, `s_addr_ok`, `s_data_ok`, `err_unexp_rsp`.
- Latency: zero cycles for request, accept and response (pure combinational paths); one cycle for state effects.
- Outputs settle from combinational logic only. There are no registered outputs.
- Reset during traffic discards all outstanding IDs. Later `m_data_ok` for those transactions raises `err_unexp_rsp`.
- Upstream must hold its request fields stable while `s_req` is high and `s_addr_ok` is low. The block does not latch them.

## Structure
- Shared package `sram_like_pkg`: size encodings (`SZ_BYTE` = 0, `SZ_HALF` = 1, `SZ_WORD` = 2), and a width helper for ID/count widths.
- Sub-module `sram_like_id_fifo`:
  - Parameters: width $clog2(NCH), depth MAX_OUT.
  - Ports: push, pop, din, head, count, full, empty.
  - Register-array storage.
- Round-robin selection and lock logic stay in the top module.

## Test plan
1. **Single read:** NCH=2; ch0 reads 0x1fc00000 with `m_addr_ok`=1 in the same cycle; `m_data_ok` arrives 2 cycles later with rdata 0x12345678 → `s_addr_ok[0]` in cycle 0, `s_data_ok[0]`=1 and `s_rdata`=0x12345678 in cycle 2, `s_data_ok[1]`=0 throughout.
2. **Round-robin:** both channels request continuously with `m_addr_ok`=1; `m_data_ok` is held 0 throughout → grants are 0, 1, 0, 1, then `m_req` drops (MAX_OUT=4). Then drive `m_data_ok` on 4 consecutive cycles → `s_data_ok` routes to channels 0, 1, 0, 1.
3. **Full:** MAX_OUT=4; 4 accepts with no responses → 5th cycle `m_req`=0. One `m_data_ok` → the next request is accepted the following cycle, not the same one.
4. **Lock:** ch1 granted with `m_addr_ok` low for 3 cycles while ch0 raises `s_req` in cycle 1 → `m_addr` holds ch1's address all 3 cycles. Accept in cycle 3 → ch0 is granted in cycle 4.
5. **Lock release:** ch1 drops `s_req` while locked → ch0 is granted the same cycle.
6. **Reset mid-flight:** 2 outstanding, 1-cycle reset, then `m_data_ok` → `err_unexp_rsp` pulses and no `s_data_ok` is raised. A write from ch1 with wstrb 0x3 afterwards completes normally, with `s_data_ok[1]`.
